// File: rtl/execute_stage_if.sv
// ----------------------------------------------------------------------------
// execute_stage_if
//   Bundles the pipeline-facing signals of the RV32I execute stage.
//   The master side is the decoder, register file and control unit, which
//   drive operands and control. The slave side is execute_stage, which returns
//   the ALU observation output and the registered EX->MEM results.
//
//   Signals (direction as seen from the slave):
//     stallIn, flushIn            in   pipeline control
//     dataReg1, dataReg2          in   rs1 / rs2 values
//     immValueReg                 in   sign-extended immediate
//     ALUop                       in   op[4]=immediate select, op[3:0]=function
//     writeEnableReg              in   instruction writes rd
//     writeBackAddrIn             in   rd address
//     aluResult                   out  combinational ALU output (debug)
//     writeEnableOut              out  registered write enable toward MEM
//     writeBackAddrOut            out  registered rd address toward MEM
//     dataOut                     out  registered ALU result toward MEM
//     zeroOut, ovfOut             out  registered result flags (only when
//                                      EXEC_FLAGS_EN is defined)
// ----------------------------------------------------------------------------
interface execute_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 5
);
    logic                  stallIn;
    logic                  flushIn;
    logic [DATA_W-1:0]     dataReg1;
    logic [DATA_W-1:0]     dataReg2;
    logic [DATA_W-1:0]     immValueReg;
    logic [OP_W-1:0]       ALUop;
    logic                  writeEnableReg;
    logic [REG_ADDR_W-1:0] writeBackAddrIn;
    logic [DATA_W-1:0]     aluResult;
    logic                  writeEnableOut;
    logic [REG_ADDR_W-1:0] writeBackAddrOut;
    logic [DATA_W-1:0]     dataOut;
`ifdef EXEC_FLAGS_EN
    logic                  zeroOut;
    logic                  ovfOut;
`endif

    modport master (
        output stallIn, flushIn, dataReg1, dataReg2, immValueReg, ALUop,
               writeEnableReg, writeBackAddrIn,
`ifdef EXEC_FLAGS_EN
        input  zeroOut, ovfOut,
`endif
        input  aluResult, writeEnableOut, writeBackAddrOut, dataOut
    );

    modport slave (
        input  stallIn, flushIn, dataReg1, dataReg2, immValueReg, ALUop,
               writeEnableReg, writeBackAddrIn,
`ifdef EXEC_FLAGS_EN
        output zeroOut, ovfOut,
`endif
        output aluResult, writeEnableOut, writeBackAddrOut, dataOut
    );
endinterface

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
//   Execute stage of a 5-stage RV32I pipeline: DEC->EX pipeline register,
//   combinational ALU, EX->MEM pipeline register.
//
//   Ports:
//     clk     in  rising-edge clock
//     resetN  in  synchronous active-low reset; clears both stages and has
//                 priority over stall and flush
//     bus     execute_stage_if.slave (operands, control, results)
//
//   Optional feature macro: EXEC_FLAGS_EN
//     When defined, bus.zeroOut (result == 0) and bus.ovfOut (signed overflow
//     of ADD/SUB) are registered in stage 2 alongside dataOut.
//
//   Latency: inputs sampled at edge N appear on the stage-2 outputs after
//   edge N+1. aluResult reflects the contents of stage 1.
// ----------------------------------------------------------------------------
module execute_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 5
) (
    input  logic           clk,
    input  logic           resetN,
    execute_stage_if.slave bus
);

    localparam logic [3:0] FN_ADD   = 4'd0;
    localparam logic [3:0] FN_SUB   = 4'd1;
    localparam logic [3:0] FN_SLL   = 4'd2;
    localparam logic [3:0] FN_SLT   = 4'd3;
    localparam logic [3:0] FN_SLTU  = 4'd4;
    localparam logic [3:0] FN_XOR   = 4'd5;
    localparam logic [3:0] FN_SRL   = 4'd6;
    localparam logic [3:0] FN_SRA   = 4'd7;
    localparam logic [3:0] FN_OR    = 4'd8;
    localparam logic [3:0] FN_AND   = 4'd9;
    localparam logic [3:0] FN_PASSB = 4'd10;

    // ------------------------------------------------------------------
    // Stage 1 (DEC->EX) state
    // ------------------------------------------------------------------
    logic [OP_W-1:0]       op_q,     op_d;
    logic [DATA_W-1:0]     data1_q,  data1_d;
    logic [DATA_W-1:0]     data2_q,  data2_d;
    logic [DATA_W-1:0]     imm_q,    imm_d;
    logic                  we1_q,    we1_d;
    logic [REG_ADDR_W-1:0] addr1_q,  addr1_d;

    // ------------------------------------------------------------------
    // Stage 2 (EX->MEM) state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]     data_out_q, data_out_d;
    logic                  we2_q,      we2_d;
    logic [REG_ADDR_W-1:0] addr2_q,    addr2_d;

    // ALU internals
    logic [DATA_W-1:0]     src_b_s;
    logic [4:0]            shamt_s;
    logic [DATA_W-1:0]     alu_result_s;

`ifdef EXEC_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q,  ovf_d;
    logic ovf_s;

    // Signed overflow of a + b: operands agree in sign, sum does not.
    function automatic logic add_ovf(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic [DATA_W-1:0] s);
        add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

    // Signed overflow of a - b: operands differ in sign, difference takes b's sign.
    function automatic logic sub_ovf(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic [DATA_W-1:0] d);
        sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
    endfunction
`endif

    // Stage-1 next state: stall holds, flush inserts a bubble, otherwise load.
    always_comb begin
        op_d    = op_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        we1_d   = we1_q;
        addr1_d = addr1_q;
        if (bus.stallIn) begin
            op_d    = op_q;
            data1_d = data1_q;
            data2_d = data2_q;
            imm_d   = imm_q;
            we1_d   = we1_q;
            addr1_d = addr1_q;
        end else if (bus.flushIn) begin
            op_d    = {OP_W{1'b0}};
            data1_d = {DATA_W{1'b0}};
            data2_d = {DATA_W{1'b0}};
            imm_d   = {DATA_W{1'b0}};
            we1_d   = 1'b0;
            addr1_d = {REG_ADDR_W{1'b0}};
        end else begin
            op_d    = bus.ALUop;
            data1_d = bus.dataReg1;
            data2_d = bus.dataReg2;
            imm_d   = bus.immValueReg;
            we1_d   = bus.writeEnableReg;
            addr1_d = bus.writeBackAddrIn;
        end
    end

    // Stage-1 registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            op_q    <= {OP_W{1'b0}};
            data1_q <= {DATA_W{1'b0}};
            data2_q <= {DATA_W{1'b0}};
            imm_q   <= {DATA_W{1'b0}};
            we1_q   <= 1'b0;
            addr1_q <= {REG_ADDR_W{1'b0}};
        end else begin
            op_q    <= op_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            we1_q   <= we1_d;
            addr1_q <= addr1_d;
        end
    end

    // ALU: operand B selection and function decode.
    always_comb begin
        src_b_s      = op_q[4] ? imm_q : data2_q;
        shamt_s      = src_b_s[4:0];
        alu_result_s = {DATA_W{1'b0}};
        case (op_q[3:0])
            FN_ADD:   alu_result_s = data1_q + src_b_s;
            FN_SUB:   alu_result_s = data1_q - src_b_s;
            FN_SLL:   alu_result_s = data1_q << shamt_s;
            FN_SLT:   alu_result_s = {{(DATA_W-1){1'b0}},
                                      ($signed(data1_q) < $signed(src_b_s))};
            FN_SLTU:  alu_result_s = {{(DATA_W-1){1'b0}}, (data1_q < src_b_s)};
            FN_XOR:   alu_result_s = data1_q ^ src_b_s;
            FN_SRL:   alu_result_s = data1_q >> shamt_s;
            FN_SRA:   alu_result_s = $unsigned($signed(data1_q) >>> shamt_s);
            FN_OR:    alu_result_s = data1_q | src_b_s;
            FN_AND:   alu_result_s = data1_q & src_b_s;
            FN_PASSB: alu_result_s = src_b_s;
            // Unassigned functions yield zero; write enable still flows through.
            default:  alu_result_s = {DATA_W{1'b0}};
        endcase
    end

    assign bus.aluResult = alu_result_s;

`ifdef EXEC_FLAGS_EN
    // Overflow is meaningful only for ADD and SUB.
    always_comb begin
        case (op_q[3:0])
            FN_ADD:  ovf_s = add_ovf(data1_q, src_b_s, alu_result_s);
            FN_SUB:  ovf_s = sub_ovf(data1_q, src_b_s, alu_result_s);
            default: ovf_s = 1'b0;
        endcase
    end
`endif

    // Stage-2 next state; x0 is never written so its enable is dropped here.
    always_comb begin
        data_out_d = data_out_q;
        we2_d      = we2_q;
        addr2_d    = addr2_q;
`ifdef EXEC_FLAGS_EN
        zero_d     = zero_q;
        ovf_d      = ovf_q;
`endif
        if (bus.stallIn) begin
            data_out_d = data_out_q;
            we2_d      = we2_q;
            addr2_d    = addr2_q;
`ifdef EXEC_FLAGS_EN
            zero_d     = zero_q;
            ovf_d      = ovf_q;
`endif
        end else begin
            data_out_d = alu_result_s;
            we2_d      = we1_q && (addr1_q != {REG_ADDR_W{1'b0}});
            addr2_d    = addr1_q;
`ifdef EXEC_FLAGS_EN
            zero_d     = (alu_result_s == {DATA_W{1'b0}});
            ovf_d      = ovf_s;
`endif
        end
    end

    // Stage-2 registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            data_out_q <= {DATA_W{1'b0}};
            we2_q      <= 1'b0;
            addr2_q    <= {REG_ADDR_W{1'b0}};
`ifdef EXEC_FLAGS_EN
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            data_out_q <= data_out_d;
            we2_q      <= we2_d;
            addr2_q    <= addr2_d;
`ifdef EXEC_FLAGS_EN
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign bus.dataOut          = data_out_q;
    assign bus.writeEnableOut   = we2_q;
    assign bus.writeBackAddrOut = addr2_q;
`ifdef EXEC_FLAGS_EN
    assign bus.zeroOut          = zero_q;
    assign bus.ovfOut           = ovf_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// ----------------------------------------------------------------------------
// tb_execute_stage
//   Directed self-checking bench for execute_stage. Inputs change 1 ns after
//   each rising edge and outputs are sampled at that same point, away from
//   the active edge. Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_execute_stage;

    logic clk;
    logic resetN;
    int   compared;
    int   mismatched;

    execute_stage_if #(.DATA_W(32), .REG_ADDR_W(5), .OP_W(5)) bus ();

    execute_stage #(.DATA_W(32), .REG_ADDR_W(5), .OP_W(5)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic we, input logic [4:0] rd);
        bus.ALUop           = op;
        bus.dataReg1        = d1;
        bus.dataReg2        = d2;
        bus.immValueReg     = imm;
        bus.writeEnableReg  = we;
        bus.writeBackAddrIn = rd;
    endtask

    task automatic idle();
        drive(5'h00, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    endtask

    // Issue one instruction, check the ALU after one edge and the registered
    // outputs after the second.
    task automatic issue_check(input string tag, input logic [4:0] op, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] imm, input logic we,
                               input logic [4:0] rd, input logic [31:0] exp_data,
                               input logic exp_we);
        drive(op, d1, d2, imm, we, rd);
        tick();
        check({tag, ".alu"}, bus.aluResult, exp_data);
        idle();
        tick();
        check({tag, ".data"}, bus.dataOut, exp_data);
        check({tag, ".we"}, {31'd0, bus.writeEnableOut}, {31'd0, exp_we});
        check({tag, ".rd"}, {27'd0, bus.writeBackAddrOut}, {27'd0, rd});
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        resetN     = 1'b0;
        bus.stallIn = 1'b0;
        bus.flushIn = 1'b0;
        drive(5'($urandom), $urandom, $urandom, $urandom, 1'b1, 5'($urandom_range(1, 31)));
        #1;

        // Reset for two edges with random inputs.
        tick();
        drive(5'($urandom), $urandom, $urandom, $urandom, 1'b1, 5'($urandom_range(1, 31)));
        tick();
        check("rst.data", bus.dataOut, 32'h0);
        check("rst.we", {31'd0, bus.writeEnableOut}, 32'h0);
        check("rst.rd", {27'd0, bus.writeBackAddrOut}, 32'h0);
        check("rst.alu", bus.aluResult, 32'h0);
        resetN = 1'b1;
        idle();
        tick();

        // Main function across opcodes.
        issue_check("add",   5'h00, 32'd5,        32'd7,        32'd0,        1'b1, 5'd3,  32'd12,       1'b1);
        issue_check("slti",  5'h13, 32'hFFFFFFFE, 32'd100,      32'd3,        1'b1, 5'd5,  32'd1,        1'b1);
        issue_check("sltiu", 5'h14, 32'hFFFFFFFE, 32'd100,      32'd3,        1'b1, 5'd5,  32'd0,        1'b1);
        issue_check("srai",  5'h17, 32'hFFFFFFFE, 32'd100,      32'd3,        1'b1, 5'd6,  32'hFFFFFFFF, 1'b1);
        issue_check("sub",   5'h01, 32'd3,        32'd5,        32'd0,        1'b1, 5'd7,  32'hFFFFFFFE, 1'b1);
        issue_check("sll33", 5'h02, 32'd1,        32'd33,       32'd0,        1'b1, 5'd8,  32'd2,        1'b1);
        issue_check("xor",   5'h05, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        1'b1, 5'd9,  32'hFF00FF00, 1'b1);
        issue_check("srl",   5'h06, 32'h80000000, 32'd31,       32'd0,        1'b1, 5'd10, 32'd1,        1'b1);
        issue_check("or",    5'h08, 32'h00FF0000, 32'h000000FF, 32'd0,        1'b1, 5'd11, 32'h00FF00FF, 1'b1);
        issue_check("and",   5'h09, 32'hFF00FF00, 32'h0F0F0F0F, 32'd0,        1'b1, 5'd12, 32'h0F000F00, 1'b1);
        issue_check("lui",   5'h1A, 32'd0,        32'hDEADBEEF, 32'h12345000, 1'b1, 5'd13, 32'h12345000, 1'b1);
        issue_check("op11",  5'h0B, 32'd9,        32'd4,        32'd0,        1'b1, 5'd14, 32'd0,        1'b1);
        issue_check("x0",    5'h00, 32'd5,        32'd7,        32'd0,        1'b1, 5'd0,  32'd12,       1'b0);

        // Flush turns a valid instruction into a bubble.
        drive(5'h00, 32'd5, 32'd7, 32'd0, 1'b1, 5'd3);
        bus.flushIn = 1'b1;
        tick();
        bus.flushIn = 1'b0;
        check("flush.alu", bus.aluResult, 32'd0);
        idle();
        tick();
        check("flush.data", bus.dataOut, 32'd0);
        check("flush.we", {31'd0, bus.writeEnableOut}, 32'd0);

        // Stall for three edges with flush asserted; result delivered once.
        drive(5'h01, 32'd10, 32'd3, 32'd0, 1'b1, 5'd7);
        tick();
        idle();
        bus.stallIn = 1'b1;
        bus.flushIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.data", bus.dataOut, 32'd0);
            check("stall.we", {31'd0, bus.writeEnableOut}, 32'd0);
            check("stall.alu", bus.aluResult, 32'd7);
        end
        bus.stallIn = 1'b0;
        bus.flushIn = 1'b0;
        tick();
        check("stall.rel.data", bus.dataOut, 32'd7);
        check("stall.rel.we", {31'd0, bus.writeEnableOut}, 32'd1);
        check("stall.rel.rd", {27'd0, bus.writeBackAddrOut}, 32'd7);
        tick();
        check("stall.once.data", bus.dataOut, 32'd0);
        check("stall.once.we", {31'd0, bus.writeEnableOut}, 32'd0);

        // Reset mid-stream overrides stall.
        drive(5'h00, 32'd5, 32'd7, 32'd0, 1'b1, 5'd3);
        tick();
        resetN      = 1'b0;
        bus.stallIn = 1'b1;
        tick();
        check("midrst.data", bus.dataOut, 32'd0);
        check("midrst.alu", bus.aluResult, 32'd0);
        resetN      = 1'b1;
        bus.stallIn = 1'b0;
        drive(5'h00, 32'd20, 32'd22, 32'd0, 1'b1, 5'd4);
        tick();
        check("midrst.e1.we", {31'd0, bus.writeEnableOut}, 32'd0);
        idle();
        tick();
        check("midrst.e2.data", bus.dataOut, 32'd42);
        check("midrst.e2.we", {31'd0, bus.writeEnableOut}, 32'd1);

`ifdef EXEC_FLAGS_EN
        // Flags: signed overflow and zero detection.
        drive(5'h00, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b1, 5'd2);
        tick();
        idle();
        tick();
        check("flag.addovf.ovf", {31'd0, bus.ovfOut}, 32'd1);
        check("flag.addovf.zero", {31'd0, bus.zeroOut}, 32'd0);
        drive(5'h01, 32'd4, 32'd4, 32'd0, 1'b1, 5'd2);
        tick();
        idle();
        tick();
        check("flag.sub0.zero", {31'd0, bus.zeroOut}, 32'd1);
        check("flag.sub0.ovf", {31'd0, bus.ovfOut}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
